// File: rtl/csr_pkg.sv
// Machine-mode CSR addresses and Zicsr funct3 opcodes shared by the CSR file
// and its users.
package csr_pkg;

    localparam logic [11:0] MIE_ADDR      = 12'h304;
    localparam logic [11:0] MTVEC_ADDR    = 12'h305;
    localparam logic [11:0] MSCRATCH_ADDR = 12'h340;
    localparam logic [11:0] MEPC_ADDR     = 12'h341;
    localparam logic [11:0] MCAUSE_ADDR   = 12'h342;

    localparam logic [2:0] CSR_RW  = 3'b001;
    localparam logic [2:0] CSR_RS  = 3'b010;
    localparam logic [2:0] CSR_RC  = 3'b011;
    localparam logic [2:0] CSR_RWI = 3'b101;
    localparam logic [2:0] CSR_RSI = 3'b110;
    localparam logic [2:0] CSR_RCI = 3'b111;

endpackage

// File: rtl/csr_controller.sv
// Machine-mode CSR file: Zicsr read-modify-write on mie/mtvec/mscratch/mepc/mcause,
// trap capture of mepc/mcause, and direct exports for interrupt and PC logic.
module csr_controller
    import csr_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  opcode_i,
    input  logic [11:0] addr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] mcause_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] imm_data_i,
    input  logic        write_enable_i,
    input  logic        trap_i,
    output logic [31:0] read_data_o,
    output logic [31:0] mie_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mtvec_o
);

    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;

    logic [31:0] w_old;
    logic [31:0] w_wdata;
    logic        w_op_valid;
    logic        w_wr;
    logic        w_we_mie;
    logic        w_we_mtvec;
    logic        w_we_mscratch;
    logic        w_we_mepc;
    logic        w_we_mcause;

    always_comb begin
        w_old = '0;
        case (addr_i)
            MIE_ADDR:      w_old = r_mie;
            MTVEC_ADDR:    w_old = r_mtvec;
            MSCRATCH_ADDR: w_old = r_mscratch;
            MEPC_ADDR:     w_old = r_mepc;
            MCAUSE_ADDR:   w_old = r_mcause;
            default:       w_old = '0;
        endcase
    end

    always_comb begin
        w_wdata    = '0;
        w_op_valid = 1'b1;
        case (opcode_i)
            CSR_RW:  w_wdata = rs1_data_i;
            CSR_RS:  w_wdata = rs1_data_i | w_old;
            CSR_RC:  w_wdata = ~rs1_data_i & w_old;
            CSR_RWI: w_wdata = imm_data_i;
            CSR_RSI: w_wdata = imm_data_i | w_old;
            CSR_RCI: w_wdata = ~imm_data_i & w_old;
            default: w_op_valid = 1'b0;
        endcase
    end

    assign w_wr          = write_enable_i & w_op_valid;
    assign w_we_mie      = w_wr & (addr_i == MIE_ADDR);
    assign w_we_mtvec    = w_wr & (addr_i == MTVEC_ADDR);
    assign w_we_mscratch = w_wr & (addr_i == MSCRATCH_ADDR);
    assign w_we_mepc     = w_wr & (addr_i == MEPC_ADDR);
    assign w_we_mcause   = w_wr & (addr_i == MCAUSE_ADDR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mie      <= '0;
            r_mtvec    <= '0;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
        end else begin
            if (w_we_mie)      r_mie      <= w_wdata;
            if (w_we_mtvec)    r_mtvec    <= w_wdata;
            if (w_we_mscratch) r_mscratch <= w_wdata;
            // A trap overrides a same-cycle CSR write to mepc/mcause.
            if (trap_i) begin
                r_mepc   <= pc_i;
                r_mcause <= mcause_i;
            end else begin
                if (w_we_mepc)   r_mepc   <= w_wdata;
                if (w_we_mcause) r_mcause <= w_wdata;
            end
        end
    end

    assign read_data_o = w_old;
    assign mie_o       = r_mie;
    assign mepc_o      = r_mepc;
    assign mtvec_o     = r_mtvec;

endmodule

// File: tb/tb_csr_controller.sv
// Directed bench for csr_controller: expectations are queued as stimulus is
// driven and checked just after the clock edge that should produce them.
module tb_csr_controller;
    import csr_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [2:0]  opcode_i = '0;
    logic [11:0] addr_i = '0;
    logic [31:0] pc_i = '0;
    logic [31:0] mcause_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] imm_data_i = '0;
    logic        write_enable_i = 1'b0;
    logic        trap_i = 1'b0;
    logic [31:0] read_data_o;
    logic [31:0] mie_o;
    logic [31:0] mepc_o;
    logic [31:0] mtvec_o;

    csr_controller dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .opcode_i       (opcode_i),
        .addr_i         (addr_i),
        .pc_i           (pc_i),
        .mcause_i       (mcause_i),
        .rs1_data_i     (rs1_data_i),
        .imm_data_i     (imm_data_i),
        .write_enable_i (write_enable_i),
        .trap_i         (trap_i),
        .read_data_o    (read_data_o),
        .mie_o          (mie_o),
        .mepc_o         (mepc_o),
        .mtvec_o        (mtvec_o)
    );

    always #5 clk_i = ~clk_i;

    localparam int SEL_READ  = 0;
    localparam int SEL_MIE   = 1;
    localparam int SEL_MEPC  = 2;
    localparam int SEL_MTVEC = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic want(input string tag, input int sel, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic step();
        exp_t        x;
        logic [31:0] obs;
        @(posedge clk_i);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            case (x.sel)
                SEL_MIE:   obs = mie_o;
                SEL_MEPC:  obs = mepc_o;
                SEL_MTVEC: obs = mtvec_o;
                default:   obs = read_data_o;
            endcase
            n_cmp++;
            assert (obs === x.exp) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
            end
        end
    endtask

    // One CSR instruction cycle; read_data_o is checked after the edge.
    task automatic csr(input string tag, input logic [2:0] op, input logic [11:0] a,
                       input logic [31:0] rs1, input logic [31:0] imm,
                       input logic [31:0] exp_read);
        opcode_i       = op;
        addr_i         = a;
        rs1_data_i     = rs1;
        imm_data_i     = imm;
        write_enable_i = 1'b1;
        want(tag, SEL_READ, exp_read);
        step();
        write_enable_i = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] e);
        addr_i         = a;
        write_enable_i = 1'b0;
        want(tag, SEL_READ, e);
        step();
    endtask

    initial begin
        // reset, with a write and a trap competing that must lose
        rst_i = 1'b1;
        trap_i = 1'b1;
        pc_i = 32'h0000_BEEF;
        mcause_i = 32'h0000_0007;
        opcode_i = CSR_RW;
        addr_i = MIE_ADDR;
        rs1_data_i = 32'hFFFF_FFFF;
        write_enable_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        trap_i = 1'b0;
        write_enable_i = 1'b0;
        want("rst_mie", SEL_MIE, 32'h0);
        want("rst_mepc", SEL_MEPC, 32'h0);
        want("rst_mtvec", SEL_MTVEC, 32'h0);
        rd("rst_read_mie", MIE_ADDR, 32'h0);
        rd("rst_read_mcause", MCAUSE_ADDR, 32'h0);

        // mtvec write
        want("rw_mtvec_out", SEL_MTVEC, 32'hDEAD_BEEF);
        want("rw_mtvec_mie", SEL_MIE, 32'h0);
        want("rw_mtvec_mepc", SEL_MEPC, 32'h0);
        csr("rw_mtvec", CSR_RW, MTVEC_ADDR, 32'hDEAD_BEEF, 32'h1111_2222, 32'hDEAD_BEEF);

        // mie set/clear
        csr("rw_mie", CSR_RW, MIE_ADDR, 32'h0000_F0F0, 32'h0, 32'h0000_F0F0);
        want("rs_mie_out", SEL_MIE, 32'h0F00_F0F1);
        csr("rs_mie", CSR_RS, MIE_ADDR, 32'h0F00_0001, 32'hFFFF_FFFF, 32'h0F00_F0F1);
        want("rc_mie_out", SEL_MIE, 32'h0F00_F000);
        csr("rc_mie", CSR_RC, MIE_ADDR, 32'h0000_00F1, 32'h0, 32'h0F00_F000);

        // mscratch immediate forms; rs1 carries junk that must be ignored
        csr("rw_mscratch", CSR_RW, MSCRATCH_ADDR, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF);
        csr("rci_mscratch", CSR_RCI, MSCRATCH_ADDR, 32'hA5A5_A5A5, 32'h0000_001F, 32'hFFFF_FFE0);
        csr("rwi_mscratch", CSR_RWI, MSCRATCH_ADDR, 32'hA5A5_A5A5, 32'h1234_5678, 32'h1234_5678);
        csr("csrr_mscratch", CSR_RS, MSCRATCH_ADDR, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678);
        csr("rc0_mscratch", CSR_RC, MSCRATCH_ADDR, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678);
        csr("rsi_mscratch", CSR_RSI, MSCRATCH_ADDR, 32'h0000_0001, 32'h8000_0000, 32'h9234_5678);

        // invalid opcodes write nothing
        csr("op000_mscratch", 3'b000, MSCRATCH_ADDR, 32'h0, 32'h0, 32'h9234_5678);
        csr("op100_mscratch", 3'b100, MSCRATCH_ADDR, 32'h0, 32'h0, 32'h9234_5678);

        // trap alone
        addr_i = MCAUSE_ADDR;
        pc_i = 32'h0000_1234;
        mcause_i = 32'h8000_000B;
        trap_i = 1'b1;
        want("trap_mcause", SEL_READ, 32'h8000_000B);
        want("trap_mepc", SEL_MEPC, 32'h0000_1234);
        want("trap_mie", SEL_MIE, 32'h0F00_F000);
        want("trap_mtvec", SEL_MTVEC, 32'hDEAD_BEEF);
        step();
        trap_i = 1'b0;
        want("idle_mepc", SEL_MEPC, 32'h0000_1234);
        rd("idle_mcause", MCAUSE_ADDR, 32'h8000_000B);

        // trap beats a same-cycle mepc write
        trap_i = 1'b1;
        pc_i = 32'h0000_0400;
        mcause_i = 32'h0000_0002;
        want("trap_vs_wr_mepc", SEL_MEPC, 32'h0000_0400);
        csr("trap_vs_wr_read", CSR_RW, MEPC_ADDR, 32'hAAAA_0000, 32'h0, 32'h0000_0400);
        trap_i = 1'b0;
        rd("trap_vs_wr_mcause", MCAUSE_ADDR, 32'h0000_0002);

        // trap beats a same-cycle mcause write
        trap_i = 1'b1;
        pc_i = 32'h0000_0600;
        mcause_i = 32'h0000_0004;
        csr("trap_vs_wr_mcause2", CSR_RW, MCAUSE_ADDR, 32'h5555_5555, 32'h0, 32'h0000_0004);
        trap_i = 1'b0;

        // mie write still commits alongside a trap
        trap_i = 1'b1;
        pc_i = 32'h0000_0800;
        mcause_i = 32'h0000_0003;
        want("trap_wr_mie_mepc", SEL_MEPC, 32'h0000_0800);
        want("trap_wr_mie_out", SEL_MIE, 32'h0000_0005);
        csr("trap_wr_mie", CSR_RW, MIE_ADDR, 32'h0000_0005, 32'h0, 32'h0000_0005);
        trap_i = 1'b0;
        rd("trap_wr_mie_mcause", MCAUSE_ADDR, 32'h0000_0003);

        // write held for two cycles: each uses the then-current old value
        opcode_i = CSR_RSI;
        addr_i = MSCRATCH_ADDR;
        imm_data_i = 32'h0000_0001;
        write_enable_i = 1'b1;
        want("hold_rsi_1", SEL_READ, 32'h9234_5679);
        step();
        imm_data_i = 32'h0000_0002;
        want("hold_rsi_2", SEL_READ, 32'h9234_567B);
        step();
        write_enable_i = 1'b0;

        // direct writes of mepc and mcause
        want("rw_mepc_out", SEL_MEPC, 32'h0000_0100);
        csr("rw_mepc", CSR_RW, MEPC_ADDR, 32'h0000_0100, 32'h0, 32'h0000_0100);
        csr("rw_mcause", CSR_RW, MCAUSE_ADDR, 32'h0000_CAFE, 32'h0, 32'h0000_CAFE);

        // unmapped address reads zero and a write there disturbs nothing
        csr("unmapped_wr", CSR_RW, 12'h300, 32'hFFFF_FFFF, 32'h0, 32'h0);
        rd("unmapped_mie", MIE_ADDR, 32'h0000_0005);
        rd("unmapped_mtvec", MTVEC_ADDR, 32'hDEAD_BEEF);
        rd("unmapped_mscratch", MSCRATCH_ADDR, 32'h9234_567B);
        rd("unmapped_mepc", MEPC_ADDR, 32'h0000_0100);
        rd("unmapped_mcause", MCAUSE_ADDR, 32'h0000_CAFE);

        // fill all five, then reset for two cycles
        csr("fill_mie", CSR_RW, MIE_ADDR, 32'h1111_1111, 32'h0, 32'h1111_1111);
        csr("fill_mtvec", CSR_RW, MTVEC_ADDR, 32'h1111_1111, 32'h0, 32'h1111_1111);
        csr("fill_mscratch", CSR_RW, MSCRATCH_ADDR, 32'h1111_1111, 32'h0, 32'h1111_1111);
        csr("fill_mepc", CSR_RW, MEPC_ADDR, 32'h1111_1111, 32'h0, 32'h1111_1111);
        csr("fill_mcause", CSR_RW, MCAUSE_ADDR, 32'h1111_1111, 32'h0, 32'h1111_1111);
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        want("rst2_mie", SEL_MIE, 32'h0);
        want("rst2_mepc", SEL_MEPC, 32'h0);
        want("rst2_mtvec", SEL_MTVEC, 32'h0);
        rd("rst2_read_mie", MIE_ADDR, 32'h0);
        rd("rst2_read_mtvec", MTVEC_ADDR, 32'h0);
        rd("rst2_read_mscratch", MSCRATCH_ADDR, 32'h0);
        rd("rst2_read_mepc", MEPC_ADDR, 32'h0);
        rd("rst2_read_mcause", MCAUSE_ADDR, 32'h0);
        rd("rst2_read_300", 12'h300, 32'h0);
        csr("rst2_wr_300", CSR_RW, 12'h300, 32'h1111_1111, 32'h0, 32'h0);
        want("rst2_after_300_mie", SEL_MIE, 32'h0);
        want("rst2_after_300_mepc", SEL_MEPC, 32'h0);
        want("rst2_after_300_mtvec", SEL_MTVEC, 32'h0);
        rd("rst2_after_300_mscratch", MSCRATCH_ADDR, 32'h0);
        rd("rst2_after_300_mcause", MCAUSE_ADDR, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/csr_controller.md
Name: csr_controller

Overview:
- Machine-mode CSR file for the RISC-V core. It holds mie, mtvec, mscratch, mepc and mcause.
- It executes the six Zicsr read-modify-write operations and returns the old CSR value for the register-file writeback.
- On a trap it captures the trapping PC and the trap cause.
- It exports mie, mepc and mtvec to the interrupt and PC logic.

Parameters:
- none (addresses and opcodes come from csr_pkg)

Ports:
- clk_i  in  1  system clock, all state on rising edge
- rst_i  in  1  synchronous reset, active-high
- opcode_i  in  3  CSR operation (funct3 encoding, csr_pkg)
- addr_i  in  12  CSR address
- pc_i  in  32  PC of the trapping instruction
- mcause_i  in  32  trap cause value
- rs1_data_i  in  32  register operand
- imm_data_i  in  32  zero-extended immediate operand (all 32 bits used)
- write_enable_i  in  1  CSR instruction valid this cycle
- trap_i  in  1  trap taken this cycle
- read_data_o  out  32  current value of CSR at addr_i
- mie_o  out  32  mie register
- mepc_o  out  32  mepc register
- mtvec_o  out  32  mtvec register

Behaviour:
- Registers: mie, mtvec, mscratch, mepc, mcause; each 32 bits, all bits writable.
- Reset: when rst_i=1 at a clock edge, all five registers are cleared to 0. rst_i has priority over trap_i and write_enable_i. Consequently mie_o, mepc_o and mtvec_o reset to 0, and read_data_o reads 0.
- Read path: read_data_o is combinational.
  - MIE_ADDR 0x304 → mie
  - MTVEC_ADDR 0x305 → mtvec
  - MSCRATCH_ADDR 0x340 → mscratch
  - MEPC_ADDR 0x341 → mepc
  - MCAUSE_ADDR 0x342 → mcause
  - any other address → 0
- Write data is computed combinationally from old = read_data_o:
  - CSR_RW: rs1
  - CSR_RS: rs1 | old
  - CSR_RC: ~rs1 & old
  - CSR_RWI: imm
  - CSR_RSI: imm | old
  - CSR_RCI: ~imm & old
- Write: when write_enable_i=1 and opcode_i is one of the six valid codes, the register selected by addr_i takes the write data at the next rising edge.
  - Latency is 1 cycle; the new value is visible on read_data_o and the dedicated output in the following cycle.
  - Invalid opcodes (000, 100) and unmapped addresses write nothing.
  - RS/RC with rs1=0 (csrr) rewrites the old value unchanged.
- Trap: when trap_i=1, at the next edge mepc ← pc_i and mcause ← mcause_i. This happens regardless of opcode_i, addr_i and write_enable_i.
- Simultaneous trap and write to the same register: for mepc or mcause, the trap value wins. A CSR write to mie/mtvec/mscratch in the trap cycle still commits.
- Stability:
  - mie and mtvec change only on a CSR write to their own address.
  - mepc changes only on a trap or a CSR write to MEPC_ADDR.
  - No register changes on any other cycle.
- write_enable_i is held for one cycle per instruction. Holding it for consecutive cycles performs one write per cycle, each using the then-current old value.

Decomposition:
- csr_pkg holds:
  - address constants MIE_ADDR=12'h304, MTVEC_ADDR=12'h305, MSCRATCH_ADDR=12'h340, MEPC_ADDR=12'h341, MCAUSE_ADDR=12'h342
  - opcode constants CSR_RW=3'b001, CSR_RS=3'b010, CSR_RC=3'b011, CSR_RWI=3'b101, CSR_RSI=3'b110, CSR_RCI=3'b111
- No sub-module. Implement as a single module: write-data mux, address decoder generating per-register enables, five registers, and the read mux.

Test Plan:
- Reset, then CSR_RW addr 0x305 rs1=0xDEADBEEF we=1 for one cycle → next cycle mtvec_o=0xDEADBEEF and read_data_o=0xDEADBEEF; mie_o and mepc_o stay 0.
- mie=0x0000F0F0, then CSR_RS rs1=0x0F000001 → mie_o=0x0F00F0F1; then CSR_RC rs1=0x000000F1 → mie_o=0x0F00F000.
- mscratch=0xFFFFFFFF, then CSR_RCI imm=0x0000001F → read 0xFFFFFFE0; then CSR_RWI imm=0x12345678 → read 0x12345678; then CSR_RS rs1=0 → unchanged.
- trap_i=1 for one cycle with pc_i=0x00001234, mcause_i=0x8000000B, addr_i=0x342, we=0 → next cycle mepc_o=0x00001234 and read_data_o=0x8000000B; mie_o and mtvec_o unchanged.
- Same-cycle trap_i=1 and CSR_RW addr 0x341 rs1=0xAAAA0000 with pc_i=0x00000400 → mepc_o=0x00000400.
- Write 0x11111111 to all five CSRs, assert rst_i for 2 cycles → all outputs and all reads return 0; addr 0x300 reads 0, and a write to it changes nothing.
